// File: rtl/ad_frame_rd.sv
// Drains tagged 18-bit words from a sample FIFO, aligns them to
// first/middle/last frame boundaries and presents whole frames on a valid/ready port.
module ad_frame_rd #(
    parameter int unsigned FRAME_LEN = 6,
    parameter int unsigned ERR_W     = 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      enable,
    input  logic                      fifo_empty,
    output logic                      fifo_rden,
    input  logic [17:0]               fifo_rdata,
    output logic                      frame_valid,
    input  logic                      frame_ready,
    output logic [16*FRAME_LEN-1:0]   frame_data,
    output logic [15:0]               frame_cnt,
    output logic [ERR_W-1:0]          err_cnt,
    output logic                      in_sync
);

    localparam int unsigned IDX_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [1:0] TAG_MID   = 2'b00;
    localparam logic [1:0] TAG_FIRST = 2'b01;
    localparam logic [1:0] TAG_LAST  = 2'b10;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [IDX_W-1:0]              r_idx;
    logic [IDX_W-1:0]              w_idx_nxt;
    logic [IDX_W-1:0]              w_wr_idx;
    logic                          r_pend;
    logic                          r_rden;
    logic                          r_valid;
    logic                          r_in_sync;
    logic [15:0]                   r_frame_cnt;
    logic [ERR_W-1:0]              r_err_cnt;
    logic [FRAME_LEN-1:0][15:0]    r_frame_data;
    logic                          w_wr_en;
    logic                          w_err_inc;
    logic                          w_hs;
    logic                          w_rden_nxt;
    logic [1:0]                    w_tag;
    logic [15:0]                   w_sample;

    assign w_tag       = fifo_rdata[17:16];
    assign w_sample    = fifo_rdata[15:0];
    assign w_hs        = r_valid & frame_ready;

    assign fifo_rden   = r_rden;
    assign frame_valid = r_valid;
    assign frame_data  = r_frame_data;
    assign frame_cnt   = r_frame_cnt;
    assign err_cnt     = r_err_cnt;
    assign in_sync     = r_in_sync;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_HUNT;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next state, slot write and error decode; words are only judged in the pending cycle
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_wr_en     = 1'b0;
        w_wr_idx    = r_idx;
        w_err_inc   = 1'b0;
        w_rden_nxt  = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (r_pend && w_tag == TAG_FIRST) begin
                    w_wr_en     = 1'b1;
                    w_wr_idx    = '0;
                    w_idx_nxt   = IDX_W'(1);
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (r_pend) begin
                    if (w_tag == TAG_FIRST) begin
                        // index 0 is the post-delivery slot where a first word is expected
                        w_err_inc = (r_idx != '0);
                        w_wr_en   = 1'b1;
                        w_wr_idx  = '0;
                        w_idx_nxt = IDX_W'(1);
                    end else if (r_idx == '0) begin
                        w_state_nxt = ST_HUNT;
                    end else if (w_tag == TAG_MID && r_idx != LAST_IDX) begin
                        w_wr_en   = 1'b1;
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end else if (w_tag == TAG_LAST && r_idx == LAST_IDX) begin
                        w_wr_en     = 1'b1;
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_PRESENT;
                    end else begin
                        w_err_inc   = 1'b1;
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_HUNT;
                    end
                end
            end
            ST_PRESENT: begin
                if (w_hs) begin
                    w_state_nxt = ST_COLLECT;
                    w_idx_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_HUNT;
                w_idx_nxt   = '0;
            end
        endcase
        // r_rden high means the next cycle is a pending cycle, so skip it
        w_rden_nxt = (w_state_nxt != ST_PRESENT) && enable && !fifo_empty && !r_rden;
    end

    // Registered strobes, flags and counters
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rden      <= 1'b0;
            r_pend      <= 1'b0;
            r_valid     <= 1'b0;
            r_in_sync   <= 1'b0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_rden    <= w_rden_nxt;
            r_pend    <= r_rden;
            r_valid   <= (w_state_nxt == ST_PRESENT);
            r_in_sync <= (w_state_nxt != ST_HUNT);
            if (w_hs) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_err_inc && r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
        end
    end

    // Frame slots keep stale words until overwritten
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_frame_data <= '0;
        end else begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                if (w_wr_en && w_wr_idx == IDX_W'(i)) begin
                    r_frame_data[i] <= w_sample;
                end
            end
        end
    end

endmodule
